// File: rtl/sram_like_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sram_like_slave                                        |
// | Description : Responder for the sram-like req/addr_ok/data_ok        |
// |               protocol, backed by an on-chip word array. Requests    |
// |               are queued in order and answered after a fixed latency.|
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sram_like_slave #(
   parameter int ADDR_WIDTH = 12,
   parameter int DEPTH      = 4,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [3:0]  wstrb,
   input  logic [31:0] wdata,
   input  logic        stall,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata
);

   localparam int               c_ptr_w    = $clog2(DEPTH);
   localparam int               c_cnt_w    = $clog2(DEPTH + 1);
   localparam int               c_words    = 1 << ADDR_WIDTH;
   localparam logic [3:0]       c_lat_init = 4'(LATENCY - 1);
   localparam logic [c_cnt_w-1:0] c_depth  = c_cnt_w'(DEPTH);

   // Backing store; intentionally never reset so contents survive resetn.
   logic [31:0]            mem_q   [c_words];

   // Response queue entries and their next-state copies.
   logic                   wr_q    [DEPTH];
   logic                   wr_d    [DEPTH];
   logic [31:0]            rdata_q [DEPTH];
   logic [31:0]            rdata_d [DEPTH];
   logic [3:0]             cnt_q   [DEPTH];
   logic [3:0]             cnt_d   [DEPTH];
   logic                   vld_q   [DEPTH];
   logic                   vld_d   [DEPTH];

   logic [c_ptr_w-1:0]     wptr_q, wptr_d;
   logic [c_ptr_w-1:0]     rptr_q, rptr_d;
   logic [c_cnt_w-1:0]     count_q, count_d;

   logic [ADDR_WIDTH-1:0]  w_idx;
   logic                   w_push;
   logic                   w_pop;

   // size, the byte offset and the aliasing upper address bits do not affect storage.
   logic                   w_unused_bits;
   assign w_unused_bits = ^{size, addr[31:ADDR_WIDTH+2], addr[1:0]};

   assign w_idx   = addr[ADDR_WIDTH+1:2];
   // Outputs depend only on state, stall and resetn, never on req/addr/wdata.
   assign data_ok = (count_q != '0) && (cnt_q[rptr_q] == 4'd0);
   assign addr_ok = resetn && !stall && ((count_q < c_depth) || data_ok);
   assign w_push  = req && addr_ok;
   assign w_pop   = data_ok;
   assign rdata   = (data_ok && !wr_q[rptr_q]) ? rdata_q[rptr_q] : 32'h0;

   // Next-state for the queue: countdown, pop at head, push at tail.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      for (int i = 0; i < DEPTH; i++) begin
         wr_d[i]    = wr_q[i];
         rdata_d[i] = rdata_q[i];
         vld_d[i]   = vld_q[i];
         cnt_d[i]   = (vld_q[i] && (cnt_q[i] != 4'd0)) ? (cnt_q[i] - 4'd1) : cnt_q[i];
      end
      // Pop before push so a full queue can recycle the head slot in one edge.
      if (w_pop) begin
         vld_d[rptr_q] = 1'b0;
         rptr_d        = rptr_q + c_ptr_w'(1);
      end
      if (w_push) begin
         vld_d[wptr_q]   = 1'b1;
         wr_d[wptr_q]    = wr;
         rdata_d[wptr_q] = wr ? 32'h0 : mem_q[w_idx];
         cnt_d[wptr_q]   = c_lat_init;
         wptr_d          = wptr_q + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
         2'b10:   count_d = count_q + c_cnt_w'(1);
         2'b01:   count_d = count_q - c_cnt_w'(1);
         default: count_d = count_q;
      endcase
   end

   // Queue state registers; reset discards every in-flight request.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            wr_q[i]    <= 1'b0;
            rdata_q[i] <= 32'h0;
            cnt_q[i]   <= 4'd0;
            vld_q[i]   <= 1'b0;
         end
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            wr_q[i]    <= wr_d[i];
            rdata_q[i] <= rdata_d[i];
            cnt_q[i]   <= cnt_d[i];
            vld_q[i]   <= vld_d[i];
         end
      end
   end

   // Byte-lane write into the array at the accept edge.
   always_ff @(posedge clk) begin
      if (w_push && wr) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
               mem_q[w_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/sram_like_slave.md
# sram_like_slave

Responder end of the sram-like request/response protocol issued by the core's fetch and memory stages (req/wr/size/addr/wstrb/wdata out, addr_ok/data_ok/rdata back). One instance serves one port (inst or data) and is backed by an on-chip word array. It accepts requests through the addr_ok handshake, queues them in order, and returns one data_ok per request after a fixed, parameterised latency. A stall input injects back-pressure, so the bench can exercise the core's handshake logic without an AXI bridge.

## Interface
- ADDR_WIDTH, 12, word-index bits; the array holds 2^ADDR_WIDTH 32-bit words.
- DEPTH, 4, maximum outstanding requests; power of 2, ≥2.
- LATENCY, 2, cycles from accept edge to data_ok sample edge; 1..15.
- clk  in  1  clock; all state changes on posedge.
- resetn  in  1  reset, asynchronous, active-low.
- req  in  1  request valid.
- wr  in  1  1 = write, 0 = read.
- size  in  2  0 = byte, 1 = half, 2 = word; informational only.
- addr  in  32  byte address.
- wstrb  in  4  write byte-lane enables.
- wdata  in  32  write data.
- stall  in  1  test hook; 1 forces addr_ok=0.
- addr_ok  out  1  request accepted at this edge if req=1.
- data_ok  out  1  response for the oldest outstanding request.
- rdata  out  32  read data; valid only with data_ok on a read.

## Operation
- **Accept:** a request is accepted at a posedge where req && addr_ok.
- **addr_ok rule:** addr_ok = resetn && !stall && (count < DEPTH || data_ok). It is combinational from state only and never depends on req.
- **Indexing:** word index = addr[ADDR_WIDTH+1:2]. Upper bits alias. addr[1:0] and size are ignored by storage; no alignment checks.
- **Write:** at the accept edge, lane i of mem[index] ← wdata[8i+7:8i] for each wstrb[i]=1. wstrb=0 is a legal no-op write that still gets a data_ok.
- **Read:** at the accept edge, the full 32-bit mem[index] is captured into the queue entry. Lane extraction belongs to the core.
  - Reads therefore observe every write accepted at an earlier edge (strict program order).
- **Queue:** circular FIFO of DEPTH entries {wr, rdata, cnt}. wptr/rptr wrap modulo DEPTH; count is 0..DEPTH.
- **Countdown:** on push, cnt ← LATENCY-1. Each cycle, every valid entry with cnt≠0 decrements.
- **Response:** data_ok = (count≠0) && head.cnt==0. The head is popped at any edge where data_ok=1; the requester must always take data_ok.
  - rdata = head.rdata when data_ok && !head.wr, else 32'h0.
- **Ordering:** responses are strictly in order. A younger entry never becomes ready before the head.
- **Push and pop in the same edge:** count unchanged; addr_ok stays 1 even when full.
- **Full with no pop:** addr_ok=0; req is held by the core and not accepted.
- **Reset (any time):** count, pointers and cnt are cleared; in-flight requests are discarded and never produce data_ok. Memory contents are not reset.

## Timing
- **Reset values:** addr_ok=0, data_ok=0, rdata=0 while resetn=0. The first accept is possible at the first edge after resetn rises.
- **Latency:** accept at edge T → data_ok high in the cycle sampled by edge T+LATENCY (LATENCY=1 gives data_ok the very next cycle).
- **Throughput:** one request per cycle sustained when DEPTH ≥ LATENCY; otherwise ≤ DEPTH/LATENCY.
- **Stall:** affects addr_ok in the same cycle; pending entries continue to count down and respond during stall.
- **Paths:** no combinational path from req/addr/wdata to any output.

## Test plan
1. **Reset:** hold resetn=0 with req=1 → addr_ok=0, data_ok=0, rdata=0. Release → addr_ok=1 in the next cycle, and the first request is accepted at the following edge.
2. **Write then read (LATENCY=2):** write addr=0x1000, wdata=0xDEADBEEF, wstrb=F at edge T; read 0x1000 at edge T+1 → data_ok at T+2 (rdata=0) and at T+3 (rdata=0xDEADBEEF).
3. **Byte lanes:** write 0x1000, wstrb=4'b0010, wdata=0x0000AB00, then read 0x1000 → 0xDEADABEF. Read 0x1001 with size=0 → same word 0xDEADABEF.
4. **Streaming (DEPTH=4, LATENCY=2):** 8 back-to-back reads of preloaded words 0..7 → addr_ok stays 1; data_ok is high 8 consecutive cycles starting 2 edges after the first accept, returning words 0..7 in order.
5. **Full (DEPTH=4, LATENCY=8):** req held at 1 → 4 accepts, then addr_ok=0 until the first data_ok. The fifth request is accepted on that same pop edge and count stays 4. Add stall=1 for 3 cycles → no accepts, but data_ok continues.
6. **Reset mid-flight:** with 2 reads outstanding, pulse resetn low for 1 cycle → no data_ok afterwards. A subsequent read of 0x1000 still returns 0xDEADABEF (memory retained).
